// File: rtl/grey_seg_display.sv
// ---------------------------------------------------------------------------
// grey_seg_display: Gray-step checker, wrap counter and two-digit 7-seg mux
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module grey_seg_display #(
   parameter int REFRESH_DIV    = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       R,
   input  logic [3:0] gray,
   input  logic       ceo,
   output logic [3:0] bin,
   output logic [3:0] wraps,
   output logic       step,
   output logic       err,
   output logic [6:0] seg,
   output logic [1:0] dig_sel
);

   localparam logic [6:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [15:0] PC_LAST  = 16'(REFRESH_DIV - 1);
   localparam logic [3:0]  GRAY_TOP = 4'b1000;

   function automatic logic [3:0] g2b(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      for (int i = 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [3:0] b2g(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   // Patterns are held in active-low gfedcba form and inverted at the output if needed.
   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'h0: p = 7'b1000000;
         4'h1: p = 7'b1111001;
         4'h2: p = 7'b0100100;
         4'h3: p = 7'b0110000;
         4'h4: p = 7'b0011001;
         4'h5: p = 7'b0010010;
         4'h6: p = 7'b0000010;
         4'h7: p = 7'b1111000;
         4'h8: p = 7'b0000000;
         4'h9: p = 7'b0010000;
         4'hA: p = 7'b0001000;
         4'hB: p = 7'b0000011;
         4'hC: p = 7'b1000110;
         4'hD: p = 7'b0100001;
         4'hE: p = 7'b0000110;
         default: p = 7'b0001110;
      endcase
      return p;
   endfunction

   logic [3:0]  gray_q;
   logic        ceo_q;
   logic [3:0]  prev;
   logic [15:0] pc;

   logic [3:0]  nxt_gray;
   logic        step_ok;
   logic        step_bad;
   logic        ceo_bad;
   logic        pc_wrap;
   logic [3:0]  shown_digit;
   logic [6:0]  seg_pat;

   always_comb begin
      nxt_gray    = b2g(g2b(prev) + 4'd1);
      step_ok     = (gray_q == nxt_gray);
      step_bad    = (gray_q != prev) && !step_ok;
      ceo_bad     = ceo_q && (gray_q != GRAY_TOP);
      pc_wrap     = (pc == PC_LAST);
      shown_digit = (dig_sel == 2'b01) ? bin : wraps;
      seg_pat     = SEG_ACTIVE_LOW ? decode(shown_digit) : ~decode(shown_digit);
   end

   always_ff @(posedge clk) begin
      if (!R) begin
         gray_q  <= '0;
         ceo_q   <= 1'b0;
         prev    <= '0;
         bin     <= '0;
         wraps   <= '0;
         step    <= 1'b0;
         err     <= 1'b0;
         pc      <= '0;
         dig_sel <= 2'b01;
         seg     <= SEG_OFF;
      end else begin
         gray_q <= gray;
         ceo_q  <= ceo;
         prev   <= gray_q;
         bin    <= g2b(gray_q);
         step   <= step_ok;
         if (step_bad || ceo_bad) begin
            err <= 1'b1;
         end
         // CEO is a per-cycle enable: a held strobe counts every cycle.
         if (ceo_q) begin
            wraps <= wraps + 4'd1;
         end
         if (pc_wrap) begin
            pc      <= '0;
            dig_sel <= {dig_sel[0], dig_sel[1]};
         end else begin
            pc <= pc + 16'd1;
         end
         seg <= seg_pat;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_grey_seg_display.sv
// ---------------------------------------------------------------------------
// tb_grey_seg_display: scoreboard bench for grey_seg_display
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_grey_seg_display;

   logic       clk = 1'b0;
   logic       R;
   logic [3:0] gray;
   logic       ceo;
   logic [3:0] bin;
   logic [3:0] wraps;
   logic       step;
   logic       err;
   logic [6:0] seg;
   logic [1:0] dig_sel;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [3:0] step_q[$];

   grey_seg_display #(
      .REFRESH_DIV    (4),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk     (clk),
      .R       (R),
      .gray    (gray),
      .ceo     (ceo),
      .bin     (bin),
      .wraps   (wraps),
      .step    (step),
      .err     (err),
      .seg     (seg),
      .dig_sel (dig_sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] g, input logic c);
      gray = g;
      ceo  = c;
      cyc();
   endtask

   // Legal advance: the scoreboard expects a step pulse showing bin b.
   task automatic adv(input logic [3:0] g, input logic [3:0] b, input logic c);
      step_q.push_back(b);
      drive(g, c);
   endtask

   always @(negedge clk) begin : monitor
      logic [3:0] e;
      if (R === 1'b1 && step === 1'b1) begin
         total_cnt++;
         if (step_q.size() == 0) begin
            $display("FAIL step_unexpected: got step with bin %0h, required no step", bin);
         end else begin
            e = step_q.pop_front();
            if (bin === e) pass_cnt++;
            else $display("FAIL step_bin: got %0h, required %0h", bin, e);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0] gseq [16];
      logic [6:0] exp_seg [8];
      logic [1:0] exp_dig [8];
      logic [1:0] prev_d;
      logic       found;

      gseq    = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
      exp_seg = '{7'h30, 7'h08, 7'h08, 7'h08, 7'h08, 7'h30, 7'h30, 7'h30};
      exp_dig = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};

      // Reset held with garbage inputs
      R = 1'b0; gray = 4'b0101; ceo = 1'b1;
      cyc(); cyc(); cyc();
      check("rst_bin",     bin,     4'h0);
      check("rst_wraps",   wraps,   4'h0);
      check("rst_step",    step,    1'b0);
      check("rst_err",     err,     1'b0);
      check("rst_seg",     seg,     7'h7F);
      check("rst_dig_sel", dig_sel, 2'b01);

      gray = 4'h0; ceo = 1'b0; R = 1'b1;
      cyc();
      check("seg_zero",       seg,   7'h40);
      check("wraps_after_rst", wraps, 4'h0);

      // Full count with CEO on Gray 8, then back to 0
      drive(4'h0, 1'b0);
      for (int i = 1; i < 16; i++) begin
         adv(gseq[i], 4'(i), (i == 15));
      end
      adv(4'h0, 4'h0, 1'b0);
      drive(4'h0, 1'b0);
      drive(4'h0, 1'b0);
      check("full_wraps", wraps, 4'h1);
      check("full_err",   err,   1'b0);
      check("full_bin",   bin,   4'h0);

      // Held enable mid-sequence
      adv(4'h1, 4'h1, 1'b0);
      adv(4'h3, 4'h2, 1'b0);
      drive(4'h3, 1'b0);
      drive(4'h3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(4'h3, 1'b0);
         check("hold_step", step, 1'b0);
      end
      check("hold_err", err, 1'b0);

      // Illegal jump Gray 3 -> Gray 7
      drive(4'h7, 1'b0);
      check("err_not_yet", err, 1'b0);
      drive(4'h7, 1'b0);
      check("err_set", err, 1'b1);
      adv(4'h5, 4'h6, 1'b0);
      adv(4'h4, 4'h7, 1'b0);
      drive(4'h4, 1'b0);
      drive(4'h4, 1'b0);
      drive(4'h4, 1'b0);
      check("err_sticky", err, 1'b1);
      check("bin_after_jump", bin, 4'h7);

      R = 1'b0;
      drive(4'h0, 1'b0);
      check("rst2_err",   err,   1'b0);
      check("rst2_wraps", wraps, 4'h0);
      R = 1'b1;
      drive(4'h0, 1'b0);

      // Bad CEO while Gray 6
      adv(4'h1, 4'h1, 1'b0);
      adv(4'h3, 4'h2, 1'b0);
      adv(4'h2, 4'h3, 1'b0);
      check("pre_badceo_err", err, 1'b0);
      adv(4'h6, 4'h4, 1'b1);
      drive(4'h6, 1'b0);
      drive(4'h6, 1'b0);
      drive(4'h6, 1'b0);
      check("badceo_wraps", wraps, 4'h1);
      check("badceo_err",   err,   1'b1);

      R = 1'b0;
      drive(4'h0, 1'b0);
      R = 1'b1;

      // Display mux with bin = 3, wraps = 10
      for (int i = 0; i < 10; i++) drive(4'h0, 1'b1);
      drive(4'h0, 1'b0);
      adv(4'h1, 4'h1, 1'b0);
      adv(4'h3, 4'h2, 1'b0);
      adv(4'h2, 4'h3, 1'b0);
      drive(4'h2, 1'b0);
      drive(4'h2, 1'b0);
      drive(4'h2, 1'b0);
      check("disp_bin",   bin,   4'h3);
      check("disp_wraps", wraps, 4'hA);

      prev_d = dig_sel;
      found  = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         cyc();
         if (dig_sel == 2'b10 && prev_d == 2'b01) found = 1'b1;
         else prev_d = dig_sel;
      end
      check("toggle_seen", found, 1'b1);
      if (found) begin
         for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc();
            check("mux_dig_sel", dig_sel, exp_dig[k]);
            check("mux_seg",     seg,     exp_seg[k]);
         end
      end

      check("step_queue_drained", step_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/grey_seg_display.md
# grey_seg_display

Downstream consumer of the 4-bit Gray counter with clock enable. It samples the counter's Gray output and CEO strobe, and converts the count to binary. It checks that every change is a legal single Gray step, counts terminal-count wraps, and time-multiplexes the binary count and wrap count onto a two-digit 7-segment display.

## Interface
- REFRESH_DIV, 16: clock cycles each digit stays selected; legal range 2..65535.
- SEG_ACTIVE_LOW, 1: 1 = segments lit when 0; 0 = lit when 1.

- clk  in  1  system clock; all state updates on its rising edge.
- R  in  1  reset, synchronous, active-low.
- gray  in  4  Gray count from the counter's out port.
- ceo  in  1  counter CEO strobe: high while the count is 15 and ce is high.
- bin  out  4  registered binary equivalent of the sampled Gray count.
- wraps  out  4  binary wrap count, modulo 16.
- step  out  1  one-cycle pulse per valid Gray advance.
- err  out  1  sticky sequence-error flag.
- seg  out  7  segments, bit order {g,f,e,d,c,b,a}.
- dig_sel  out  2  one-hot digit enable: 01 = bin digit, 10 = wraps digit.

## Operation
- **Stage 1 (every edge):**
  - gray_q <= gray
  - ceo_q <= ceo
- **Stage 2 (every edge):**
  - prev <= gray_q
  - bin <= g2b(gray_q), where b[3] = g[3] and b[i] = b[i+1] ^ g[i].
- **Step check (stage 2), with nxt = b2g(g2b(prev)+1 mod 16):**
  - gray_q == prev: no action; step = 0.
  - gray_q == nxt: step = 1 for one cycle.
  - Any other value (multi-bit jump, reversal, skip): err <= 1, step = 0.
  - err clears only on reset.
- **Wrap handling (stage 2):**
  - ceo_q = 1: wraps <= wraps + 1 (15 wraps to 0).
  - ceo_q = 1 while gray_q != 4'b1000 (Gray 15): err <= 1; wraps still increments.
  - ceo_q held high for N cycles: wraps increments N times. The block does not edge-detect; CEO is a level-per-cycle enable.
- **Display mux:**
  - Prescaler pc counts 0..REFRESH_DIV-1 and wraps to 0.
  - When pc == REFRESH_DIV-1, dig_sel toggles 01 <-> 10 on the same edge as the wrap.
  - seg <= decode(dig_sel == 01 ? bin : wraps) every edge, so seg lags dig_sel and the digit values by one cycle.
- **Decode (active-low form, gfedcba):**
  - Digits 0-7: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000.
  - Digits 8-F: 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
  - SEG_ACTIVE_LOW = 0 inverts all patterns.

## Timing
- **Reset (R = 0 at an edge)**, next cycle:
  - gray_q, prev, bin, wraps, pc = 0; ceo_q, step, err = 0.
  - dig_sel = 01.
  - seg = all segments off (7'h7F if active-low, 7'h00 otherwise).
- Reset wins over every simultaneous event: a CEO strobe, a bad step or a prescaler wrap in the reset cycle is discarded.
- First sample after reset is compared against prev = 0; the counter's reset value 0 therefore raises no error.
- **Latency:**
  - gray change at edge N is captured into gray_q at edge N.
  - bin, step and err update at edge N+1.
  - seg reflects the new bin at edge N+2 if that digit is selected.
- ceo high before edge N increments wraps at edge N+1, the same edge where bin shows 15. The following counter step gives bin = 0 one cycle later.
- Throughput: one Gray advance per cycle is supported (ce tied high).

## Test plan
- **Reset:** hold R = 0 for 3 cycles with gray = 4'b0101 and ceo = 1 -> all outputs at their reset values; wraps = 0, err = 0, seg = 7'h7F.
- **Full count:** drive the Gray sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8 one per cycle, with ceo = 1 only during Gray 8 -> bin tracks 0..15 two cycles late; step = 1 on 15 consecutive cycles; wraps = 1; err = 0.
- **Held enable:** repeat the same Gray value for 5 cycles mid-sequence -> step = 0 during the hold, err stays 0.
- **Illegal jump:** go from Gray 3 to Gray 7 (bin 2 -> 5) -> err = 1 two cycles after the bad sample; it stays 1 through later legal steps and clears only with R = 0.
- **Bad CEO:** ceo = 1 while gray = 4'b0110 -> wraps increments and err = 1.
- **Display mux:** REFRESH_DIV = 4, bin = 3, wraps = 10 -> dig_sel alternates 01/10 every 4 cycles; seg = 0110000 then 0001000, each lagging dig_sel by one cycle.
